spu_cmd_sequencer: RTL and testbench
====================================

// Module: spu_cmd_sequencer
// PURPOSE
//  Upstream stage of the spatial processing unit (SPU) core. Assembles 2-beat byte commands
//  from the pin interface into operand packets {OpSel,D,C,B,A}. Queues them in a small FIFO.
//  Issues each to the SPU datapath over a valid/ready handshake, one command per cycle max.
//  Lets the host stream focal-mean / Manhattan / box-area / tensor-multiply jobs without
//  holding the pins static.
// PARAMETERS
//  DEPTH  4  FIFO entries; power of two, >=2
//  CNT_W  8  width of issued-command counter
// PORTS
//  clk        in   1      sole clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  clr        in   1      synchronous flush: drop staged beat and all queued commands
//  in_valid   in   1      host byte valid
//  in_data    in   8      beat0={B[7:4],A[3:0]}; beat1={OpSel[7:6],D[5:3],C[2:0]}
//  in_ready   out  1      byte accepted when in_valid&in_ready at clk edge
//  cmd_valid  out  1      head command available to SPU core
//  cmd_ready  in   1      SPU core consumes head when cmd_valid&cmd_ready
//  cmd_a      out  4      operand A (head)
//  cmd_b      out  4      operand B
//  cmd_c      out  3      operand C
//  cmd_d      out  3      operand D
//  cmd_op     out  2      OpSel: 00 focal mean, 01 Manhattan, 10 box area, 11 tensor mul
//  fifo_level out  log2(DEPTH)+1  queued entries
//  issued_cnt out  CNT_W  commands handed to core, saturating at all-ones
// BEHAVIOUR
//  - Reset (async, rst=1): phase=BEAT0, staging reg=0, FIFO empty, all outputs 0.
//    in_ready=1 once rst deasserts.
//  - Beat FSM: BEAT0 --accept--> BEAT1 --accept--> BEAT0. Other transitions hold.
//    BEAT0 accept latches in_data into 8-bit staging reg.
//    BEAT1 accept pushes {in_data,staging} (16 bits) into the FIFO.
//  - in_ready = (phase==BEAT0) | !full. Beat0 is always accepted.
//    Beat1 stalls only while full; no same-cycle pop bypass when full.
//  - cmd_valid = !empty; cmd_* driven from FIFO head storage (registered, no comb path from in_*).
//  - Latency: beat1 accepted at edge k into empty FIFO -> cmd_valid=1 after edge k.
//    Pop requires valid&ready.
//  - Simultaneous push+pop (not full, not empty): level unchanged, order preserved.
//  - Push+pop at level 1 is legal; the new entry becomes head next cycle.
//  - Full: level==DEPTH. Beat1 held with in_valid=1 and in_ready=0 until a pop.
//    No data lost, no overwrite.
//  - Empty: cmd_valid=0; cmd_ready ignored; cmd_* hold last head value (don't-care for checks).
//  - Pointers wrap modulo DEPTH. Level derived from extra pointer bit.
//  - clr=1 (priority over push/pop that cycle): phase->BEAT0, FIFO empty, issued_cnt kept.
//    Byte presented that cycle is discarded.
//  - issued_cnt increments on each pop; saturates at 2^CNT_W-1; cleared only by rst.
//  - rst mid-command: partial beat0 discarded; all queued commands lost.
//  - in_valid/cmd_ready are sampled only at clk edges. Inputs must not be X while rst=0.
// STRUCTURE
//  - spu_pkg: OP_FOCAL_MEAN=2'b00, OP_MANHATTAN=2'b01, OP_BOX_AREA=2'b10, OP_TENSOR_MUL=2'b11.
//    typedef spu_cmd_t {op[1:0],d[2:0],c[2:0],b[3:0],a[3:0]} (16 bits), beat-field offsets.
//  - Sub-module spu_cmd_fifo: generic DEPTH x 16 sync FIFO (push/pop/clr/full/empty/level).
//    Top holds beat FSM, staging reg, counter.
// TESTING
//  1. Bytes 0x84,0x16 into empty FIFO, cmd_ready=1 -> next cycle cmd_valid=1 with
//     a=4,b=8,c=6,d=2,op=00; popped; issued_cnt=1.
//  2. cmd_ready=0; send (0x35,0x79),(0x32,0x8D),(0x32,0xEC),(0x11,0x00) -> level=4;
//     5th beat1 stalls in_ready=0. Release ready: pops in order op 01,10,11,00.
//     Stalled cmd enters after first pop.
//  3. Beat0 only (0x84), then clr=1 -> phase BEAT0, level 0. Next pair 0x32,0x8D yields
//     a=2,b=3,c=5,d=1,op=10 (no stale B/A).
//  4. Level 2, push+pop same cycle for 6 cycles -> level stays 2. Outputs match a
//     scoreboard in order across pointer wrap.
//  5. Assert rst mid-beat1 with level 3 -> outputs 0 immediately (async).
//     After release, in_ready=1, cmd_valid=0.
//  6. 300 back-to-back commands with CNT_W=8 -> issued_cnt saturates at 255.

Source files
------------

// File: rtl/spu_pkg.sv
// Shared types for the SPU command sequencer: opcode values, packed command
// layout, beat-field offsets and the beat-phase state type.
package spu_pkg;

  localparam logic [1:0] OP_FOCAL_MEAN = 2'b00;
  localparam logic [1:0] OP_MANHATTAN  = 2'b01;
  localparam logic [1:0] OP_BOX_AREA   = 2'b10;
  localparam logic [1:0] OP_TENSOR_MUL = 2'b11;

  localparam int unsigned B0_A_LSB  = 0;
  localparam int unsigned B0_B_LSB  = 4;
  localparam int unsigned B1_C_LSB  = 0;
  localparam int unsigned B1_D_LSB  = 3;
  localparam int unsigned B1_OP_LSB = 6;

  typedef struct packed {
    logic [1:0] op;
    logic [2:0] d;
    logic [2:0] c;
    logic [3:0] b;
    logic [3:0] a;
  } spu_cmd_t;

  typedef enum logic {
    BEAT0 = 1'b0,
    BEAT1 = 1'b1
  } beat_state_e;

  function automatic spu_cmd_t pack_cmd(input logic [7:0] beat1, input logic [7:0] beat0);
    spu_cmd_t cmd;
    cmd.a  = beat0[B0_A_LSB +: 4];
    cmd.b  = beat0[B0_B_LSB +: 4];
    cmd.c  = beat1[B1_C_LSB +: 3];
    cmd.d  = beat1[B1_D_LSB +: 3];
    cmd.op = beat1[B1_OP_LSB +: 2];
    return cmd;
  endfunction

endpackage

// File: rtl/spu_cmd_fifo.sv
// Generic DEPTH x spu_cmd_t synchronous FIFO; head read directly from storage,
// level derived from the extra pointer bit.
module spu_cmd_fifo
  import spu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  spu_cmd_t                     push_data,
  input  logic                         pop,
  output spu_cmd_t                     pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       level
);

  localparam int unsigned AW = $clog2(DEPTH);

  spu_cmd_t       mem_q [DEPTH];
  spu_cmd_t       mem_d [DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic           do_push, do_pop;

  assign level    = wr_ptr_q - rd_ptr_q;
  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_data;
        wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/spu_cmd_sequencer.sv
// Assembles 2-beat host byte commands into SPU operand packets, queues them
// and issues them to the SPU core over valid/ready.
module spu_cmd_sequencer
  import spu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [3:0]               cmd_a,
  output logic [3:0]               cmd_b,
  output logic [2:0]               cmd_c,
  output logic [2:0]               cmd_d,
  output logic [1:0]               cmd_op,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         issued_cnt
);

  beat_state_e       state_q, state_d;
  logic [7:0]        stage_q, stage_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              full, empty;
  logic              accept, push, pop;
  spu_cmd_t          head;

  // Gated by rst so the pin reads 0 while reset is held, 1 as soon as it drops.
  assign in_ready = ~rst & ((state_q == BEAT0) | ~full);
  assign accept   = in_valid & in_ready;
  assign push     = accept & (state_q == BEAT1) & ~clr;
  assign pop      = ~empty & cmd_ready & ~clr;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = BEAT0;
      stage_d = '0;
    end else if (accept) begin
      case (state_q)
        BEAT0: begin
          stage_d = in_data;
          state_d = BEAT1;
        end
        BEAT1: state_d = BEAT0;
        default: state_d = BEAT0;
      endcase
    end
    if (pop && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BEAT0;
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  spu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .push      (push),
    .push_data (pack_cmd(in_data, stage_q)),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  assign cmd_valid  = ~empty;
  assign cmd_a      = head.a;
  assign cmd_b      = head.b;
  assign cmd_c      = head.c;
  assign cmd_d      = head.d;
  assign cmd_op     = head.op;
  assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_spu_cmd_sequencer.sv
// Self-checking bench for spu_cmd_sequencer: directed vector table, queue-based
// reference model under random traffic, and hand sequences for reset/saturation.
module tb_spu_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_MAX = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [3:0]  cmd_a, cmd_b;
  logic [2:0]  cmd_c, cmd_d;
  logic [1:0]  cmd_op;
  logic [2:0]  fifo_level;
  logic [7:0]  issued_cnt;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: queue of {beat1,beat0} words, beat phase, staged byte, count.
  logic [15:0] mq[$];
  bit          m_phase = 0;
  logic [7:0]  m_stage = '0;
  int          m_cnt = 0;

  typedef struct {
    bit         c;
    bit         iv;
    logic [7:0] d;
    bit         cr;
    bit         e_rdy;
    bit         e_val;
    int         e_lvl;
    logic [15:0] e_cmd;
    int         e_cnt;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  spu_cmd_sequencer #(
    .DEPTH (4),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_c      (cmd_c),
    .cmd_d      (cmd_d),
    .cmd_op     (cmd_op),
    .fifo_level (fifo_level),
    .issued_cnt (issued_cnt)
  );

  wire [15:0] dut_cmd = {cmd_op, cmd_d, cmd_c, cmd_b, cmd_a};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit rdy;
    bit do_pop;
    rdy = (m_phase == 0) || (mq.size() < DEPTH);
    if (clr) begin
      mq.delete();
      m_phase = 0;
    end else begin
      do_pop = (mq.size() > 0) && cmd_ready;
      if (do_pop) begin
        void'(mq.pop_front());
        if (m_cnt < CNT_MAX) m_cnt++;
      end
      if (in_valid && rdy) begin
        if (m_phase == 0) begin
          m_stage = in_data;
          m_phase = 1;
        end else begin
          mq.push_back({in_data, m_stage});
          m_phase = 0;
        end
      end
    end
  endtask

  task automatic step(input bit c, input bit iv, input logic [7:0] d, input bit cr);
    clr = c;
    in_valid = iv;
    in_data = d;
    cmd_ready = cr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'((m_phase == 0) || (mq.size() < DEPTH)));
    chk({tag, ".cmd_valid"}, 32'(cmd_valid), 32'(mq.size() > 0));
    chk({tag, ".level"}, 32'(fifo_level), 32'(mq.size()));
    chk({tag, ".issued"}, 32'(issued_cnt), 32'(m_cnt));
    if (mq.size() > 0) chk({tag, ".head"}, 32'(dut_cmd), 32'(mq[0]));
  endtask

  task automatic addv(input bit c, input bit iv, input logic [7:0] d, input bit cr,
                      input bit e_rdy, input bit e_val, input int e_lvl,
                      input logic [15:0] e_cmd, input int e_cnt);
    vec_t v;
    v.c = c; v.iv = iv; v.d = d; v.cr = cr;
    v.e_rdy = e_rdy; v.e_val = e_val; v.e_lvl = e_lvl; v.e_cmd = e_cmd; v.e_cnt = e_cnt;
    vq.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b0, b1;

    // Reset state while rst is held
    #12;
    chk("rst.in_ready", 32'(in_ready), 0);
    chk("rst.cmd_valid", 32'(cmd_valid), 0);
    chk("rst.level", 32'(fifo_level), 0);
    chk("rst.issued", 32'(issued_cnt), 0);
    chk("rst.cmd", 32'(dut_cmd), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rel.in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    // Directed vectors: single command, fill/stall/drain order, clr behaviour
    addv(0,1,8'h84,1, 1,0,0,16'h0000,0);
    addv(0,1,8'h16,1, 1,1,1,16'h1684,0);
    addv(0,0,8'h00,1, 1,0,0,16'h0000,1);
    addv(0,1,8'h35,0, 1,0,0,16'h0000,1);
    addv(0,1,8'h79,0, 1,1,1,16'h7935,1);
    addv(0,1,8'h32,0, 1,1,1,16'h7935,1);
    addv(0,1,8'h8D,0, 1,1,2,16'h7935,1);
    addv(0,1,8'h32,0, 1,1,2,16'h7935,1);
    addv(0,1,8'hEC,0, 1,1,3,16'h7935,1);
    addv(0,1,8'h11,0, 1,1,3,16'h7935,1);
    addv(0,1,8'h00,0, 1,1,4,16'h7935,1);
    addv(0,1,8'h84,0, 0,1,4,16'h7935,1);
    addv(0,1,8'h16,0, 0,1,4,16'h7935,1);
    addv(0,1,8'h16,1, 1,1,3,16'h8D32,2);
    addv(0,1,8'h16,1, 1,1,3,16'hEC32,3);
    addv(0,0,8'h00,1, 1,1,2,16'h0011,4);
    addv(0,0,8'h00,1, 1,1,1,16'h1684,5);
    addv(0,0,8'h00,1, 1,0,0,16'h0000,6);
    addv(0,1,8'h84,0, 1,0,0,16'h0000,6);
    addv(1,1,8'h32,0, 1,0,0,16'h0000,6);
    addv(0,1,8'h32,0, 1,0,0,16'h0000,6);
    addv(0,1,8'h8D,0, 1,1,1,16'h8D32,6);
    addv(0,0,8'h00,1, 1,0,0,16'h0000,7);
    addv(0,1,8'h35,0, 1,0,0,16'h0000,7);
    addv(0,1,8'h79,0, 1,1,1,16'h7935,7);
    addv(1,0,8'h00,1, 1,0,0,16'h0000,7);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].c, vq[i].iv, vq[i].d, vq[i].cr);
      chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vq[i].e_rdy));
      chk($sformatf("vec%0d.cmd_valid", i), 32'(cmd_valid), 32'(vq[i].e_val));
      chk($sformatf("vec%0d.level", i), 32'(fifo_level), 32'(vq[i].e_lvl));
      chk($sformatf("vec%0d.issued", i), 32'(issued_cnt), 32'(vq[i].e_cnt));
      if (vq[i].e_val) chk($sformatf("vec%0d.cmd", i), 32'(dut_cmd), 32'(vq[i].e_cmd));
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0, ($urandom % 4) != 0, 8'($urandom), $urandom % 2 == 1);
      check_model($sformatf("rnd%0d", i));
    end

    // Steady level 2 with push+pop coinciding across pointer wrap
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 8'($urandom), 0);
      step(0, 1, 8'($urandom), 0);
    end
    check_model("lvl2.fill");
    for (int i = 0; i < 6; i++) begin
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      step(0, 1, b0, 0);
      check_model($sformatf("lvl2.b0_%0d", i));
      step(0, 1, b1, 1);
      check_model($sformatf("lvl2.pp%0d", i));
      chk($sformatf("lvl2.level%0d", i), 32'(fifo_level), 2);
    end

    // Async reset mid-command with level 3
    step(0, 1, 8'h21, 0);
    step(0, 1, 8'h43, 0);
    step(0, 1, 8'h65, 0);
    check_model("pre_rst");
    chk("pre_rst.level", 32'(fifo_level), 3);
    in_valid = 1'b1;
    in_data = 8'h87;
    #2;
    rst = 1'b1;
    #1;
    chk("arst.in_ready", 32'(in_ready), 0);
    chk("arst.cmd_valid", 32'(cmd_valid), 0);
    chk("arst.level", 32'(fifo_level), 0);
    chk("arst.issued", 32'(issued_cnt), 0);
    chk("arst.cmd", 32'(dut_cmd), 0);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    mq.delete();
    m_phase = 0;
    m_cnt = 0;
    chk("arst_rel.in_ready", 32'(in_ready), 1);
    chk("arst_rel.cmd_valid", 32'(cmd_valid), 0);
    check_model("arst_rel");

    // 300 back-to-back commands saturate the issued counter
    for (int i = 0; i < 300; i++) begin
      step(0, 1, 8'($urandom), 1);
      step(0, 1, 8'($urandom), 1);
      check_model($sformatf("sat%0d", i));
    end
    step(0, 0, 8'h00, 1);
    check_model("sat.drain");
    chk("sat.issued", 32'(issued_cnt), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
